// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with conditional-branch / jump resolution.
// Registers execute-stage results and control for the memory stage, feeds
// rd/regwrite/result back to forwarding, and pulses redirect_o for one cycle
// when a branch or jump is taken.
// Optional build macro EX_MEM_BRANCH_STATS_EN adds branch_cnt_o/taken_cnt_o
// counters of loaded conditional branches and of the taken ones.
module ex_mem_stage #(
  parameter int unsigned                XLEN         = 64,
  parameter int unsigned                ITYPE_W      = 3,
  parameter logic [ITYPE_W-1:0]         BRANCH_ITYPE = ITYPE_W'(4),
  parameter logic [ITYPE_W-1:0]         JUMP_ITYPE   = ITYPE_W'(5)
) (
`ifdef EX_MEM_BRANCH_STATS_EN
  output logic [31:0]          branch_cnt_o,
  output logic [31:0]          taken_cnt_o,
`endif
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic [4:0]           rd_i,
  input  logic                 regwrite_i,
  input  logic                 memread_i,
  input  logic                 memwrite_i,
  input  logic                 memtoreg_i,
  input  logic [2:0]           funct3_i,
  input  logic [ITYPE_W-1:0]   itype_i,
  input  logic [XLEN-1:0]      branch_target_i,
  input  logic                 zero_i,
  input  logic                 ltz_i,
  input  logic [XLEN-1:0]      alu_result_i,
  input  logic [XLEN-1:0]      store_data_i,
  output logic                 valid_o,
  output logic [4:0]           rd_o,
  output logic                 regwrite_o,
  output logic                 memread_o,
  output logic                 memwrite_o,
  output logic                 memtoreg_o,
  output logic [2:0]           funct3_o,
  output logic [XLEN-1:0]      alu_result_o,
  output logic [XLEN-1:0]      store_data_o,
  output logic                 redirect_o,
  output logic [XLEN-1:0]      redirect_target_o
);

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  logic r_valid;
  logic [4:0] r_rd;
  logic r_regwrite;
  logic r_memread;
  logic r_memwrite;
  logic r_memtoreg;
  logic [2:0] r_funct3;
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_store_data;
  logic r_redirect;
  logic [XLEN-1:0] r_redirect_target;

  logic w_is_branch;
  logic w_cond;
  logic w_taken;

  // Branch condition from funct3 and ALU flags; jumps are always taken
  always_comb begin
    w_cond = 1'b0;
    case (funct3_i)
      F3_BEQ:  w_cond = zero_i;
      F3_BNE:  w_cond = ~zero_i;
      F3_BLT:  w_cond = ltz_i;
      F3_BGE:  w_cond = ~ltz_i;
      default: w_cond = 1'b0;
    endcase
    w_is_branch = valid_i && (itype_i == BRANCH_ITYPE);
    w_taken     = (w_is_branch && w_cond) || (valid_i && (itype_i == JUMP_ITYPE));
  end

  // Stage register: reset > flush > stall > load
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_valid           <= 1'b0;
      r_rd              <= '0;
      r_regwrite        <= 1'b0;
      r_memread         <= 1'b0;
      r_memwrite        <= 1'b0;
      r_memtoreg        <= 1'b0;
      r_funct3          <= '0;
      r_alu_result      <= '0;
      r_store_data      <= '0;
      r_redirect        <= 1'b0;
      r_redirect_target <= '0;
    end else if (flush_i) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_redirect <= 1'b0;
    end else if (stall_i) begin
      r_redirect <= 1'b0;
    end else begin
      r_valid      <= valid_i;
      r_rd         <= rd_i;
      r_regwrite   <= valid_i & regwrite_i;
      r_memread    <= valid_i & memread_i;
      r_memwrite   <= valid_i & memwrite_i;
      r_memtoreg   <= valid_i & memtoreg_i;
      r_funct3     <= funct3_i;
      r_alu_result <= alu_result_i;
      r_store_data <= store_data_i;
      r_redirect   <= w_taken;
      if (w_taken) begin
        r_redirect_target <= branch_target_i;
      end
    end
  end

`ifdef EX_MEM_BRANCH_STATS_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_taken_cnt;

  // Count conditional branches (and taken ones) that actually enter the stage
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else if (!flush_i && !stall_i && w_is_branch) begin
      r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_cond) begin
        r_taken_cnt <= r_taken_cnt + 32'd1;
      end
    end
  end

  assign branch_cnt_o = r_branch_cnt;
  assign taken_cnt_o  = r_taken_cnt;
`endif

  assign valid_o           = r_valid;
  assign rd_o              = r_rd;
  assign regwrite_o        = r_regwrite;
  assign memread_o         = r_memread;
  assign memwrite_o        = r_memwrite;
  assign memtoreg_o        = r_memtoreg;
  assign funct3_o          = r_funct3;
  assign alu_result_o      = r_alu_result;
  assign store_data_o      = r_store_data;
  assign redirect_o        = r_redirect;
  assign redirect_target_o = r_redirect_target;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: a behavioural model compared every
// negative edge, plus literal expectations for the directed scenarios.
module tb_ex_mem_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        stall_i, flush_i, valid_i;
  logic [4:0]  rd_i;
  logic        regwrite_i, memread_i, memwrite_i, memtoreg_i;
  logic [2:0]  funct3_i;
  logic [2:0]  itype_i;
  logic [63:0] branch_target_i;
  logic        zero_i, ltz_i;
  logic [63:0] alu_result_i, store_data_i;
  logic        valid_o;
  logic [4:0]  rd_o;
  logic        regwrite_o, memread_o, memwrite_o, memtoreg_o;
  logic [2:0]  funct3_o;
  logic [63:0] alu_result_o, store_data_o;
  logic        redirect_o;
  logic [63:0] redirect_target_o;
`ifdef EX_MEM_BRANCH_STATS_EN
  logic [31:0] branch_cnt_o, taken_cnt_o;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  ex_mem_stage dut (
`ifdef EX_MEM_BRANCH_STATS_EN
    .branch_cnt_o(branch_cnt_o), .taken_cnt_o(taken_cnt_o),
`endif
    .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .rd_i(rd_i), .regwrite_i(regwrite_i), .memread_i(memread_i),
    .memwrite_i(memwrite_i), .memtoreg_i(memtoreg_i), .funct3_i(funct3_i),
    .itype_i(itype_i), .branch_target_i(branch_target_i), .zero_i(zero_i),
    .ltz_i(ltz_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .valid_o(valid_o), .rd_o(rd_o), .regwrite_o(regwrite_o), .memread_o(memread_o),
    .memwrite_o(memwrite_o), .memtoreg_o(memtoreg_o), .funct3_o(funct3_o),
    .alu_result_o(alu_result_o), .store_data_o(store_data_o),
    .redirect_o(redirect_o), .redirect_target_o(redirect_target_o)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  // Branch rule: funct3[2] picks the flag (ltz vs zero), funct3[0] inverts it,
  // funct3[1] set means the encoding is not a supported branch.
  function automatic bit model_taken(input logic [2:0] it, input logic [2:0] f3,
                                     input logic z, input logic l);
    bit flag;
    if (it == 3'd5) return 1'b1;
    if (it != 3'd4) return 1'b0;
    flag = f3[2] ? l : z;
    return (f3[1] == 1'b0) && (flag != f3[0]);
  endfunction

  // Behavioural model of the stage outputs
  logic        m_valid, m_rw, m_mr, m_mw, m_mtr, m_redir;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [63:0] m_alu, m_sd, m_tgt;
  logic [31:0] m_bcnt, m_tcnt;

  always @(posedge clk_i or posedge reset_i) begin
    bit tk;
    if (reset_i) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0; m_redir = 0;
      m_rd = 0; m_f3 = 0; m_alu = 0; m_sd = 0; m_tgt = 0; m_bcnt = 0; m_tcnt = 0;
    end else if (flush_i) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_redir = 0;
    end else if (stall_i) begin
      m_redir = 0;
    end else begin
      tk = valid_i && model_taken(itype_i, funct3_i, zero_i, ltz_i);
      m_valid = valid_i;
      m_rd    = rd_i;
      m_rw    = valid_i && regwrite_i;
      m_mr    = valid_i && memread_i;
      m_mw    = valid_i && memwrite_i;
      m_mtr   = valid_i && memtoreg_i;
      m_f3    = funct3_i;
      m_alu   = alu_result_i;
      m_sd    = store_data_i;
      m_redir = tk;
      if (tk) m_tgt = branch_target_i;
      if (valid_i && itype_i == 3'd4) begin
        m_bcnt = m_bcnt + 32'd1;
        if (tk) m_tcnt = m_tcnt + 32'd1;
      end
    end
  end

  // Compare DUT against the model away from the active edge
  always @(negedge clk_i) begin
    if (!reset_i) begin
      check("valid_o",    64'(valid_o),    64'(m_valid));
      check("regwrite_o", 64'(regwrite_o), 64'(m_rw));
      check("memread_o",  64'(memread_o),  64'(m_mr));
      check("memwrite_o", 64'(memwrite_o), 64'(m_mw));
      check("redirect_o", 64'(redirect_o), 64'(m_redir));
      check("redirect_target_o", redirect_target_o, m_tgt);
      if (m_valid) begin
        check("rd_o",         64'(rd_o),       64'(m_rd));
        check("memtoreg_o",   64'(memtoreg_o), 64'(m_mtr));
        check("funct3_o",     64'(funct3_o),   64'(m_f3));
        check("alu_result_o", alu_result_o,    m_alu);
        check("store_data_o", store_data_o,    m_sd);
      end
`ifdef EX_MEM_BRANCH_STATS_EN
      check("branch_cnt_o", 64'(branch_cnt_o), 64'(m_bcnt));
      check("taken_cnt_o",  64'(taken_cnt_o),  64'(m_tcnt));
`endif
    end
  end

  task automatic idle();
    stall_i = 0; flush_i = 0; valid_i = 0; rd_i = 0; regwrite_i = 0;
    memread_i = 0; memwrite_i = 0; memtoreg_i = 0; funct3_i = 0; itype_i = 0;
    branch_target_i = 0; zero_i = 0; ltz_i = 0; alu_result_i = 0; store_data_i = 0;
  endtask

  task automatic branch(input logic [2:0] f3, input logic z, input logic l,
                        input logic [63:0] tgt);
    idle();
    valid_i = 1; itype_i = 3'd4; funct3_i = f3; zero_i = z; ltz_i = l;
    branch_target_i = tgt;
  endtask

  initial begin
    reset_i = 1'b1;
    idle();
    repeat (2) @(negedge clk_i);
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_redirect", 64'(redirect_o), 64'd0);
    check("reset_alu", alu_result_o, 64'd0);
    reset_i = 1'b0;

    // Plain ALU op with writeback
    valid_i = 1; regwrite_i = 1; rd_i = 5'd5; alu_result_i = 64'h10; store_data_i = 64'hABCD;
    @(negedge clk_i);
    check("t2_valid", 64'(valid_o), 64'd1);
    check("t2_rd", 64'(rd_o), 64'd5);
    check("t2_alu", alu_result_o, 64'h10);
    check("t2_regwrite", 64'(regwrite_o), 64'd1);

    // Load, then bubble: control must drop with valid
    idle(); valid_i = 1; memread_i = 1; memtoreg_i = 1; funct3_i = 3'b011; rd_i = 5'd9;
    alu_result_i = 64'h1000;
    @(negedge clk_i);
    check("load_memread", 64'(memread_o), 64'd1);
    idle(); regwrite_i = 1; memread_i = 1; memwrite_i = 1;
    @(negedge clk_i);
    check("bubble_regwrite", 64'(regwrite_o), 64'd0);
    check("bubble_memwrite", 64'(memwrite_o), 64'd0);

    // BEQ taken then not taken
    branch(3'b000, 1'b1, 1'b0, 64'h200);
    @(negedge clk_i);
    check("beq_redirect", 64'(redirect_o), 64'd1);
    check("beq_target", redirect_target_o, 64'h200);
    branch(3'b000, 1'b0, 1'b0, 64'h240);
    @(negedge clk_i);
    check("beq_nt_redirect", 64'(redirect_o), 64'd0);
    check("beq_nt_target_hold", redirect_target_o, 64'h200);

    // Unsupported funct3 never taken
    branch(3'b010, 1'b1, 1'b1, 64'h280);
    @(negedge clk_i);
    check("f3_010_redirect", 64'(redirect_o), 64'd0);

    // BGE taken followed by three stalled cycles
    branch(3'b101, 1'b0, 1'b0, 64'h300); alu_result_i = 64'h44;
    @(negedge clk_i);
    check("bge_redirect", 64'(redirect_o), 64'd1);
    check("bge_target", redirect_target_o, 64'h300);
    idle(); stall_i = 1; valid_i = 1; rd_i = 5'd7; alu_result_i = 64'h99; itype_i = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("stall_redirect", 64'(redirect_o), 64'd0);
      check("stall_alu_hold", alu_result_o, 64'h44);
      check("stall_valid_hold", 64'(valid_o), 64'd1);
    end

    // Stall and flush together with a valid store that is also a jump
    idle(); stall_i = 1; flush_i = 1; valid_i = 1; memwrite_i = 1; itype_i = 3'd5;
    branch_target_i = 64'h500;
    @(negedge clk_i);
    check("sf_valid", 64'(valid_o), 64'd0);
    check("sf_memwrite", 64'(memwrite_o), 64'd0);
    check("sf_redirect", 64'(redirect_o), 64'd0);

    // Jump with link
    idle(); valid_i = 1; itype_i = 3'd5; regwrite_i = 1; rd_i = 5'd1;
    alu_result_i = 64'h104; branch_target_i = 64'h400;
    @(negedge clk_i);
    check("jal_redirect", 64'(redirect_o), 64'd1);
    check("jal_regwrite", 64'(regwrite_o), 64'd1);
    check("jal_target", redirect_target_o, 64'h400);

    // Asynchronous reset while redirect is high
    #1 reset_i = 1'b1;
    #1;
    check("areset_redirect", 64'(redirect_o), 64'd0);
    check("areset_valid", 64'(valid_o), 64'd0);
    check("areset_target", redirect_target_o, 64'd0);
    idle();
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    check("post_reset_redirect", 64'(redirect_o), 64'd0);

    // Branch statistics: 4 branches (3 taken), a jump, a flushed branch
    branch(3'b000, 1'b1, 1'b0, 64'h600); @(negedge clk_i);
    branch(3'b001, 1'b0, 1'b0, 64'h610); @(negedge clk_i);
    branch(3'b100, 1'b0, 1'b1, 64'h620); @(negedge clk_i);
    branch(3'b110, 1'b1, 1'b1, 64'h630); @(negedge clk_i);
    check("blt_prev_nt", 64'(redirect_o), 64'd0);
    idle(); valid_i = 1; itype_i = 3'd5; branch_target_i = 64'h640; @(negedge clk_i);
    branch(3'b000, 1'b1, 1'b0, 64'h650); flush_i = 1; @(negedge clk_i);
    check("flushed_br_redirect", 64'(redirect_o), 64'd0);
    idle(); @(negedge clk_i);
    check("stats_target", redirect_target_o, 64'h640);
`ifdef EX_MEM_BRANCH_STATS_EN
    check("stats_branch_cnt", 64'(branch_cnt_o), 64'd4);
    check("stats_taken_cnt", 64'(taken_cnt_o), 64'd3);
`endif
    @(negedge clk_i);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
